// File: rtl/controle_bandeja.sv
// Cork tray/reservoir controller: tracks tray and reservoir counts, decodes status
// flags and runs the dispenser motor in refill bursts of one timed window per cork.
module controle_bandeja #(
  parameter int MAX_BANDEJA = 20,
  parameter int LIMITE      = 5,
  parameter int ESTOQUE_MAX = 99,
  parameter int T_PULSO     = 4,
  parameter int W_BANDEJA   = 5,
  parameter int W_ESTOQUE   = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 AD,
  input  logic                 VR,
  input  logic                 RE,
  output logic                 MD,
  output logic                 CR,
  output logic                 BZ,
  output logic                 ES,
  output logic                 ERR,
  output logic                 ocupado,
  output logic [W_BANDEJA-1:0] cont_bandeja,
  output logic [W_ESTOQUE-1:0] cont_estoque
);

  localparam int W_T = (T_PULSO > 1) ? $clog2(T_PULSO) : 1;
  localparam logic [W_T-1:0]       T_RELOAD = W_T'(T_PULSO - 1);
  localparam logic [W_T-1:0]       T_ZERO   = '0;
  localparam logic [W_BANDEJA-1:0] B_MAX    = W_BANDEJA'(MAX_BANDEJA);
  localparam logic [W_BANDEJA-1:0] B_LIM    = W_BANDEJA'(LIMITE);
  localparam logic [W_BANDEJA-1:0] B_ZERO   = '0;
  localparam logic [W_BANDEJA-1:0] B_ONE    = W_BANDEJA'(1);
  localparam logic [W_ESTOQUE-1:0] E_MAX    = W_ESTOQUE'(ESTOQUE_MAX);
  localparam logic [W_ESTOQUE-1:0] E_ZERO   = '0;
  localparam logic [W_ESTOQUE-1:0] E_ONE    = W_ESTOQUE'(1);

  typedef enum logic [0:0] {OCIOSO = 1'b0, LIBERAR = 1'b1} estado_t;

  estado_t              state_q, state_d;
  logic [W_T-1:0]       timer_q, timer_d;
  logic [W_BANDEJA-1:0] band_q, band_d;
  logic [W_ESTOQUE-1:0] est_q, est_d;
  logic                 err_d, err_q;
  logic                 md_q, ocup_q;
  logic                 entrega_s;

  // Next-state: counter updates, delivery detection and burst sequencing
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    band_d    = band_q;
    est_d     = est_q;
    err_d     = 1'b0;
    entrega_s = (state_q == LIBERAR) && (timer_q == T_ZERO);

    // A VR coincident with a delivery cancels out, even on an empty tray
    if (entrega_s && VR) begin
      band_d = band_q;
    end else if (entrega_s && (band_q < B_MAX)) begin
      band_d = band_q + B_ONE;
    end else if (VR && (band_q != B_ZERO)) begin
      band_d = band_q - B_ONE;
    end else if (VR) begin
      err_d = 1'b1;
    end else begin
      band_d = band_q;
    end

    if (RE) begin
      est_d = E_MAX;
    end else if (entrega_s && (est_q != E_ZERO)) begin
      est_d = est_q - E_ONE;
    end else begin
      est_d = est_q;
    end

    case (state_q)
      OCIOSO: begin
        if (AD && (band_q < B_MAX) && (est_q != E_ZERO)) begin
          state_d = LIBERAR;
          timer_d = T_RELOAD;
        end else begin
          state_d = OCIOSO;
        end
      end
      LIBERAR: begin
        // Continuation uses post-update counts, so a late VR extends the burst
        if (timer_q != T_ZERO) begin
          timer_d = timer_q - W_T'(1);
        end else if ((band_d < B_MAX) && (est_d != E_ZERO)) begin
          timer_d = T_RELOAD;
        end else begin
          state_d = OCIOSO;
        end
      end
      default: begin
        state_d = OCIOSO;
        timer_d = T_ZERO;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OCIOSO;
      timer_q <= T_ZERO;
      band_q  <= B_ZERO;
      est_q   <= E_MAX;
      err_q   <= 1'b0;
      md_q    <= 1'b0;
      ocup_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      band_q  <= band_d;
      est_q   <= est_d;
      err_q   <= err_d;
      md_q    <= (state_d == LIBERAR);
      ocup_q  <= (state_d == LIBERAR);
    end
  end

  assign MD           = md_q;
  assign ocupado      = ocup_q;
  assign ERR          = err_q;
  assign cont_bandeja = band_q;
  assign cont_estoque = est_q;
  assign BZ           = (band_q == B_ZERO);
  assign CR           = (band_q <= B_LIM);
  assign ES           = (est_q == E_ZERO);

endmodule
